// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I-subset control unit.
// Contents: FSM state enum, opcode constants, ALU control codes, ALU op class,
// datapath select encodings and the DECODE-state dispatch function.
package ctrl_pkg;

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAdr   = 4'd2,
      StMemRead  = 4'd3,
      StMemWb    = 4'd4,
      StMemWrite = 4'd5,
      StExecR    = 4'd6,
      StExecI    = 4'd7,
      StAluWb    = 4'd8,
      StBeq      = 4'd9,
      StJal      = 4'd10,
      StTrap     = 4'd11
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // ALU op class requested by the FSM; AluOpFunct defers to funct3/funct7.
   typedef enum logic [1:0] {
      AluOpAdd   = 2'b00,
      AluOpSub   = 2'b01,
      AluOpFunct = 2'b10
   } alu_op_t;

   localparam logic [1:0] RES_ALU_OUT    = 2'b00;
   localparam logic [1:0] RES_READ_DATA  = 2'b01;
   localparam logic [1:0] RES_ALU_RESULT = 2'b10;

   localparam logic [1:0] SRCA_PC     = 2'b00;
   localparam logic [1:0] SRCA_OLD_PC = 2'b01;
   localparam logic [1:0] SRCA_RD1    = 2'b10;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   // Successor of DECODE; any encoding outside the supported subset traps.
   function automatic state_t decode_next(input logic [6:0] op, input logic [2:0] funct3,
                                          input logic funct7_5);
      logic f3_ok;
      f3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
              (funct3 == 3'b110) || (funct3 == 3'b111);
      case (op)
         OP_LW, OP_SW: decode_next = (funct3 == 3'b010) ? StMemAdr : StTrap;
         OP_R:         decode_next = (f3_ok && (!funct7_5 || funct3 == 3'b000)) ?
                                     StExecR : StTrap;
         OP_I:         decode_next = f3_ok ? StExecI : StTrap;
         OP_BEQ:       decode_next = (funct3 == 3'b000) ? StBeq : StTrap;
         OP_JAL:       decode_next = StJal;
         default:      decode_next = StTrap;
      endcase
   endfunction

endpackage

// File: rtl/alu_dec.sv
// ALU control decoder.
// Ports: FUNCT3, FUNCT7_5 (instruction fields), IS_R (R-type, enables sub via
// FUNCT7_5), ALU_OP (class from FSM) -> ALU_CONTROL (3-bit ALU operation).
module alu_dec
   import ctrl_pkg::*;
(
   input  logic [2:0] FUNCT3,
   input  logic       FUNCT7_5,
   input  logic       IS_R,
   input  alu_op_t    ALU_OP,
   output logic [2:0] ALU_CONTROL
);

   always_comb begin
      ALU_CONTROL = ALU_ADD;
      unique case (ALU_OP)
         AluOpAdd: ALU_CONTROL = ALU_ADD;
         AluOpSub: ALU_CONTROL = ALU_SUB;
         AluOpFunct: begin
            case (FUNCT3)
               // Immediate forms carry imm bits in [30]; only R-type may subtract.
               3'b000:  ALU_CONTROL = (IS_R && FUNCT7_5) ? ALU_SUB : ALU_ADD;
               3'b010:  ALU_CONTROL = ALU_SLT;
               3'b110:  ALU_CONTROL = ALU_OR;
               3'b111:  ALU_CONTROL = ALU_AND;
               default: ALU_CONTROL = ALU_ADD;
            endcase
         end
         default: ALU_CONTROL = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multi-cycle RV32I subset core with shared memory.
// Inputs: CLK, RST (async, active high), OP/FUNCT3/FUNCT7_5 from the IR, ZERO
// from the ALU, MEM_READY memory handshake.
// Outputs: PC/IR/memory/register write enables, datapath selects (ADR_SRC,
// RESULT_SRC, ALU_SRC_A/B, IMM_SRC), ALU_CONTROL, RETIRE pulse, sticky ILLEGAL
// trap flag and STATE for debug.
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int unsigned ALU_CTRL_W = 3
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [6:0]            OP,
   input  logic [2:0]            FUNCT3,
   input  logic                  FUNCT7_5,
   input  logic                  ZERO,
   input  logic                  MEM_READY,
   output logic                  PC_WRITE,
   output logic                  ADR_SRC,
   output logic                  MEM_WRITE,
   output logic                  IR_WRITE,
   output logic [1:0]            RESULT_SRC,
   output logic [1:0]            ALU_SRC_A,
   output logic [1:0]            ALU_SRC_B,
   output logic [1:0]            IMM_SRC,
   output logic [ALU_CTRL_W-1:0] ALU_CONTROL,
   output logic                  REG_WRITE,
   output logic                  RETIRE,
   output logic                  ILLEGAL,
   output logic [3:0]            STATE
);

   state_t     state;
   alu_op_t    alu_op;
   logic       is_r;
   logic [2:0] alu_ctrl;
   logic       pc_write_c, mem_write_c, ir_write_c, reg_write_c, retire_c;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= StFetch;
      end else begin
         case (state)
            StFetch:    if (MEM_READY) state <= StDecode;
            StDecode:   state <= decode_next(OP, FUNCT3, FUNCT7_5);
            StMemAdr:   state <= (OP == OP_SW) ? StMemWrite : StMemRead;
            StMemRead:  if (MEM_READY) state <= StMemWb;
            StMemWb:    state <= StFetch;
            StMemWrite: if (MEM_READY) state <= StFetch;
            StExecR:    state <= StAluWb;
            StExecI:    state <= StAluWb;
            StAluWb:    state <= StFetch;
            StBeq:      state <= StFetch;
            StJal:      state <= StAluWb;
            StTrap:     state <= StTrap;
            default:    state <= StTrap;
         endcase
      end
   end

   always_comb begin
      pc_write_c  = 1'b0;
      mem_write_c = 1'b0;
      ir_write_c  = 1'b0;
      reg_write_c = 1'b0;
      retire_c    = 1'b0;
      ADR_SRC     = 1'b0;
      RESULT_SRC  = RES_ALU_OUT;
      ALU_SRC_A   = SRCA_PC;
      ALU_SRC_B   = SRCB_RD2;
      IMM_SRC     = IMM_I;
      alu_op      = AluOpAdd;
      is_r        = 1'b0;
      case (state)
         StFetch: begin
            ALU_SRC_B  = SRCB_FOUR;
            RESULT_SRC = RES_ALU_RESULT;
            ir_write_c = MEM_READY;
            pc_write_c = MEM_READY;
         end
         StDecode: begin
            // Branch/jump target is precomputed here into ALU_OUT.
            ALU_SRC_A = SRCA_OLD_PC;
            ALU_SRC_B = SRCB_IMM;
            IMM_SRC   = (OP == OP_JAL) ? IMM_J : IMM_B;
         end
         StMemAdr: begin
            ALU_SRC_A = SRCA_RD1;
            ALU_SRC_B = SRCB_IMM;
            IMM_SRC   = (OP == OP_SW) ? IMM_S : IMM_I;
         end
         StMemRead: begin
            ADR_SRC = 1'b1;
         end
         StMemWb: begin
            RESULT_SRC  = RES_READ_DATA;
            reg_write_c = 1'b1;
            retire_c    = 1'b1;
         end
         StMemWrite: begin
            ADR_SRC     = 1'b1;
            mem_write_c = 1'b1;
            retire_c    = MEM_READY;
         end
         StExecR: begin
            ALU_SRC_A = SRCA_RD1;
            ALU_SRC_B = SRCB_RD2;
            alu_op    = AluOpFunct;
            is_r      = 1'b1;
         end
         StExecI: begin
            ALU_SRC_A = SRCA_RD1;
            ALU_SRC_B = SRCB_IMM;
            alu_op    = AluOpFunct;
         end
         StAluWb: begin
            reg_write_c = 1'b1;
            retire_c    = 1'b1;
         end
         StBeq: begin
            ALU_SRC_A  = SRCA_RD1;
            ALU_SRC_B  = SRCB_RD2;
            alu_op     = AluOpSub;
            pc_write_c = ZERO;
            retire_c   = 1'b1;
         end
         StJal: begin
            ALU_SRC_A  = SRCA_OLD_PC;
            ALU_SRC_B  = SRCB_FOUR;
            pc_write_c = 1'b1;
         end
         default: ;
      endcase
   end

   alu_dec u_alu_dec (
      .FUNCT3      (FUNCT3),
      .FUNCT7_5    (FUNCT7_5),
      .IS_R        (is_r),
      .ALU_OP      (alu_op),
      .ALU_CONTROL (alu_ctrl)
   );

   // FETCH enables follow MEM_READY, so they must be masked while reset is held.
   assign PC_WRITE    = pc_write_c  & ~RST;
   assign MEM_WRITE   = mem_write_c & ~RST;
   assign IR_WRITE    = ir_write_c  & ~RST;
   assign REG_WRITE   = reg_write_c & ~RST;
   assign RETIRE      = retire_c    & ~RST;
   assign ILLEGAL     = (state == StTrap);
   assign STATE       = state;
   assign ALU_CONTROL = ALU_CTRL_W'(alu_ctrl);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl: walks each instruction class
// cycle by cycle and compares outputs against hand-computed values.
module tb_multicycle_ctrl;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [6:0] OP = 7'd0;
   logic [2:0] FUNCT3 = 3'd0;
   logic       FUNCT7_5 = 1'b0;
   logic       ZERO = 1'b0;
   logic       MEM_READY = 1'b1;
   logic       PC_WRITE, ADR_SRC, MEM_WRITE, IR_WRITE, REG_WRITE, RETIRE, ILLEGAL;
   logic [1:0] RESULT_SRC, ALU_SRC_A, ALU_SRC_B, IMM_SRC;
   logic [2:0] ALU_CONTROL;
   logic [3:0] STATE;

   int n_vec = 0;
   int n_err = 0;

   multicycle_ctrl #(.ALU_CTRL_W(3)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .OP          (OP),
      .FUNCT3      (FUNCT3),
      .FUNCT7_5    (FUNCT7_5),
      .ZERO        (ZERO),
      .MEM_READY   (MEM_READY),
      .PC_WRITE    (PC_WRITE),
      .ADR_SRC     (ADR_SRC),
      .MEM_WRITE   (MEM_WRITE),
      .IR_WRITE    (IR_WRITE),
      .RESULT_SRC  (RESULT_SRC),
      .ALU_SRC_A   (ALU_SRC_A),
      .ALU_SRC_B   (ALU_SRC_B),
      .IMM_SRC     (IMM_SRC),
      .ALU_CONTROL (ALU_CONTROL),
      .REG_WRITE   (REG_WRITE),
      .RETIRE      (RETIRE),
      .ILLEGAL     (ILLEGAL),
      .STATE       (STATE)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // State plus the five one-bit enables/pulses in one call.
   task automatic cyc(input string tag, input logic [3:0] st, input logic pcw, input logic irw,
                      input logic mw, input logic rw, input logic ret);
      check({tag, ".state"}, STATE, st);
      check({tag, ".pc_write"}, 4'(PC_WRITE), 4'(pcw));
      check({tag, ".ir_write"}, 4'(IR_WRITE), 4'(irw));
      check({tag, ".mem_write"}, 4'(MEM_WRITE), 4'(mw));
      check({tag, ".reg_write"}, 4'(REG_WRITE), 4'(rw));
      check({tag, ".retire"}, 4'(RETIRE), 4'(ret));
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      @(negedge CLK);
   endtask

   task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
      OP = op;
      FUNCT3 = f3;
      FUNCT7_5 = f7;
   endtask

   initial begin
      // Reset held: FETCH selects, all enables masked even with MEM_READY=1.
      MEM_READY = 1'b1;
      settle();
      cyc("rst", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("rst.illegal", 4'(ILLEGAL), 4'd0);
      check("rst.adr_src", 4'(ADR_SRC), 4'd0);
      check("rst.src_b", 4'(ALU_SRC_B), 4'd2);
      check("rst.result_src", 4'(RESULT_SRC), 4'd2);
      tick();
      RST = 1'b0;

      // add: 0,1,6,8,0
      set_instr(7'b0110011, 3'b000, 1'b0);
      settle(); cyc("add.f", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check("add.f.alu", 4'(ALU_CONTROL), 4'd0);
      tick(); settle(); cyc("add.d", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("add.d.imm", 4'(IMM_SRC), 4'd2);
      check("add.d.src_a", 4'(ALU_SRC_A), 4'd1);
      tick(); settle(); cyc("add.ex", 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("add.ex.alu", 4'(ALU_CONTROL), 4'd0);
      check("add.ex.src_a", 4'(ALU_SRC_A), 4'd2);
      check("add.ex.src_b", 4'(ALU_SRC_B), 4'd0);
      tick(); settle(); cyc("add.wb", 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      check("add.wb.result_src", 4'(RESULT_SRC), 4'd0);
      tick(); settle(); cyc("add.end", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      // sub via EXEC_R, FUNCT7_5=1
      set_instr(7'b0110011, 3'b000, 1'b1);
      tick(); tick(); settle();
      check("sub.ex.state", STATE, 4'd6);
      check("sub.ex.alu", 4'(ALU_CONTROL), 4'd1);
      tick(); tick();

      // I-type ALU table; FUNCT7_5=1 must not turn addi into sub.
      begin
         logic [2:0] f3s [4] = '{3'b000, 3'b010, 3'b110, 3'b111};
         logic [3:0] alus [4] = '{4'd0, 4'd5, 4'd3, 4'd2};
         for (int i = 0; i < 4; i++) begin
            set_instr(7'b0010011, f3s[i], 1'b1);
            tick(); tick(); settle();
            check($sformatf("iop%0d.state", i), STATE, 4'd7);
            check($sformatf("iop%0d.alu", i), 4'(ALU_CONTROL), alus[i]);
            check($sformatf("iop%0d.imm", i), 4'(IMM_SRC), 4'd0);
            tick(); tick();
         end
      end

      // lw: 2 FETCH waits, 3 MEM_READ waits, 10 cycles total.
      set_instr(7'b0000011, 3'b010, 1'b0);
      MEM_READY = 1'b0;
      for (int i = 0; i < 2; i++) begin
         settle(); cyc($sformatf("lw.fw%0d", i), 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         tick();
      end
      MEM_READY = 1'b1;
      settle(); cyc("lw.f", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick(); settle(); cyc("lw.d", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); settle(); cyc("lw.adr", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("lw.adr.imm", 4'(IMM_SRC), 4'd0);
      MEM_READY = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(); settle(); cyc($sformatf("lw.rw%0d", i), 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         check($sformatf("lw.rw%0d.adr_src", i), 4'(ADR_SRC), 4'd1);
      end
      tick(); MEM_READY = 1'b1;
      settle(); cyc("lw.rd", 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); settle(); cyc("lw.wb", 4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      check("lw.wb.result_src", 4'(RESULT_SRC), 4'd1);
      tick(); settle(); check("lw.end.state", STATE, 4'd0);

      // sw with one wait cycle in MEM_WRITE.
      set_instr(7'b0100011, 3'b010, 1'b0);
      tick(); settle(); cyc("sw.d", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); settle(); cyc("sw.adr", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("sw.adr.imm", 4'(IMM_SRC), 4'd1);
      tick(); MEM_READY = 1'b0;
      settle(); cyc("sw.wait", 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("sw.wait.adr_src", 4'(ADR_SRC), 4'd1);
      tick(); MEM_READY = 1'b1;
      settle(); cyc("sw.wr", 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      tick(); settle(); check("sw.end.state", STATE, 4'd0);

      // beq taken then not taken, 3 cycles each.
      set_instr(7'b1100011, 3'b000, 1'b0);
      for (int z = 1; z >= 0; z--) begin
         ZERO = 1'(z);
         tick(); settle(); check($sformatf("beq%0d.d", z), STATE, 4'd1);
         tick(); settle();
         cyc($sformatf("beq%0d.br", z), 4'd9, 1'(z), 1'b0, 1'b0, 1'b0, 1'b1);
         check($sformatf("beq%0d.alu", z), 4'(ALU_CONTROL), 4'd1);
         tick(); settle(); check($sformatf("beq%0d.end", z), STATE, 4'd0);
      end
      ZERO = 1'b0;

      // jal: DECODE uses J immediate, JAL writes PC, ALU_WB writes rd.
      set_instr(7'b1101111, 3'b000, 1'b0);
      tick(); settle(); check("jal.d.state", STATE, 4'd1);
      check("jal.d.imm", 4'(IMM_SRC), 4'd3);
      tick(); settle(); cyc("jal.j", 4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("jal.j.src_a", 4'(ALU_SRC_A), 4'd1);
      check("jal.j.src_b", 4'(ALU_SRC_B), 4'd2);
      tick(); settle(); cyc("jal.wb", 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      tick(); settle(); check("jal.end", STATE, 4'd0);

      // Illegal R-type (slt with funct7[5]=1) traps.
      set_instr(7'b0110011, 3'b010, 1'b1);
      tick(); tick(); settle();
      check("badr.state", STATE, 4'd11);
      check("badr.illegal", 4'(ILLEGAL), 4'd1);
      #3 RST = 1'b1;
      tick(); RST = 1'b0;

      // OP=0 traps; sticky for 20 cycles with no enables.
      set_instr(7'b0000000, 3'b000, 1'b0);
      tick(); tick();
      for (int i = 0; i < 20; i++) begin
         settle();
         cyc($sformatf("trap%0d", i), 4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         check($sformatf("trap%0d.illegal", i), 4'(ILLEGAL), 4'd1);
         tick();
      end
      // Asynchronous reset mid-cycle takes effect immediately.
      #2 RST = 1'b1;
      #1;
      check("arst.state", STATE, 4'd0);
      check("arst.illegal", 4'(ILLEGAL), 4'd0);
      check("arst.ir_write", 4'(IR_WRITE), 4'd0);
      check("arst.pc_write", 4'(PC_WRITE), 4'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore control FSM that sequences the core as a multi-cycle RV32I subset (lw, sw, R-type add/sub/and/or/slt, addi/andi/ori/slti, beq, jal) over one shared instruction/data memory.
- Drives all datapath selects and write enables: PC, instruction register, register file, ALU, extender, memory address mux.
- Tolerates variable memory latency via a MEM_READY handshake.
- Flags unsupported encodings by trapping.

Parameters:
- ALU_CTRL_W, 3, width of ALU_CONTROL.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous active-high reset.
- OP  in  7  INSTR[6:0] from instruction register.
- FUNCT3  in  3  INSTR[14:12].
- FUNCT7_5  in  1  INSTR[30].
- ZERO  in  1  ALU zero flag.
- MEM_READY  in  1  memory completes current access this cycle.
- PC_WRITE  out  1  load PC from result bus.
- ADR_SRC  out  1  memory address: 0 = PC, 1 = result bus.
- MEM_WRITE  out  1  memory write strobe.
- IR_WRITE  out  1  latch INSTR and OLD_PC.
- RESULT_SRC  out  2  00 = ALU_OUT register, 01 = read data, 10 = ALU result.
- ALU_SRC_A  out  2  00 = PC, 01 = OLD_PC, 10 = RD1.
- ALU_SRC_B  out  2  00 = RD2, 01 = IMM_EXT, 10 = constant 4.
- IMM_SRC  out  2  00 = I, 01 = S, 10 = B, 11 = J.
- ALU_CONTROL  out  ALU_CTRL_W  000 add, 001 sub, 010 and, 011 or, 101 slt.
- REG_WRITE  out  1  register file write enable.
- RETIRE  out  1  one-cycle pulse on the last cycle of each instruction.
- ILLEGAL  out  1  sticky trap flag.
- STATE  out  4  current state, debug.

Behaviour:
- States and encodings: FETCH 0, DECODE 1, MEM_ADR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC_R 6, EXEC_I 7, ALU_WB 8, BEQ 9, JAL 10, TRAP 11.
- Reset:
  - RST high forces state to FETCH asynchronously.
  - While RST is high, every write enable (PC_WRITE, IR_WRITE, MEM_WRITE, REG_WRITE) is 0; RETIRE = 0, ILLEGAL = 0, STATE = 0.
  - Other selects take their FETCH values.
  - Reset mid-instruction abandons it; no partial writes after RST asserts.
- Outputs are combinational from state; ALU_CONTROL also depends on FUNCT3/FUNCT7_5. Unlisted outputs are 0.
- FETCH:
  - ADR_SRC=0, ALU_SRC_A=00, ALU_SRC_B=10, add, RESULT_SRC=10.
  - IR_WRITE = PC_WRITE = MEM_READY.
  - Stay in FETCH while MEM_READY=0, else go to DECODE.
- DECODE:
  - ALU_SRC_A=01, ALU_SRC_B=01, add; IMM_SRC=11 if jal, else 10. This precomputes the branch/jump target into ALU_OUT.
  - Next state by OP: 0000011 with FUNCT3=010, or 0100011 with FUNCT3=010 -> MEM_ADR.
  - OP 0110011 with legal funct -> EXEC_R.
  - OP 0010011 with FUNCT3 in {000,010,110,111} -> EXEC_I.
  - OP 1100011 with FUNCT3=000 -> BEQ.
  - OP 1101111 -> JAL.
  - Anything else -> TRAP.
  - Legal R-type: FUNCT3 in {000,010,110,111}; FUNCT7_5=1 only with FUNCT3=000.
- MEM_ADR: ALU_SRC_A=10, ALU_SRC_B=01, add; IMM_SRC=00 for lw, 01 for sw. Next state MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: ADR_SRC=1, RESULT_SRC=00. Wait for MEM_READY, then go to MEM_WB.
- MEM_WB: RESULT_SRC=01, REG_WRITE=1, RETIRE=1. Next state FETCH.
- MEM_WRITE:
  - ADR_SRC=1, RESULT_SRC=00, MEM_WRITE=1 held until MEM_READY.
  - RETIRE=MEM_READY; go to FETCH on MEM_READY.
- EXEC_R: ALU_SRC_A=10, ALU_SRC_B=00. ALU op: 000 gives sub if FUNCT7_5 else add; 010 slt; 110 or; 111 and. Next state ALU_WB.
- EXEC_I: ALU_SRC_A=10, ALU_SRC_B=01, IMM_SRC=00. Same ALU op table but FUNCT7_5 ignored (000 is always add). Next state ALU_WB.
- ALU_WB: RESULT_SRC=00, REG_WRITE=1, RETIRE=1. Next state FETCH.
- BEQ:
  - ALU_SRC_A=10, ALU_SRC_B=00, sub, RESULT_SRC=00.
  - PC_WRITE=ZERO, RETIRE=1. Next state FETCH.
- JAL:
  - ALU_SRC_A=01, ALU_SRC_B=10, add, RESULT_SRC=00, PC_WRITE=1.
  - Next state ALU_WB, which writes OLD_PC+4 to rd.
- TRAP:
  - All enables 0, ILLEGAL=1.
  - Remains in TRAP until RST.
- Latencies with MEM_READY tied 1: lw 5 cycles; sw 4; R/I-type 4; beq 3; jal 4. Each wait cycle adds 1.

Decomposition:
- ctrl_pkg holds:
  - state enum;
  - OP constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL);
  - ALU_CONTROL codes;
  - RESULT_SRC, ALU_SRC_A, ALU_SRC_B and IMM_SRC encodings.
- One combinational sub-module, alu_dec: inputs FUNCT3, FUNCT7_5, IS_R and ALU_OP class (add/sub/funct); output ALU_CONTROL.
- The FSM stays in multicycle_ctrl.

Test Plan:
- Reset then add (OP=0110011, FUNCT3=000, FUNCT7_5=0), MEM_READY=1 -> STATE sequence 0,1,6,8,0; ALU_CONTROL=000 in EXEC_R; REG_WRITE=1 only in ALU_WB; RETIRE one pulse.
- lw with MEM_READY low for 2 cycles in FETCH and 3 cycles in MEM_READ -> IR_WRITE only on the cycle MEM_READY=1; total 10 cycles; REG_WRITE in MEM_WB with RESULT_SRC=01.
- sw (OP=0100011, FUNCT3=010) -> IMM_SRC=01 in MEM_ADR; MEM_WRITE=1 held until MEM_READY; ADR_SRC=1; no REG_WRITE.
- beq with ZERO=1 then ZERO=0 -> PC_WRITE=1 then 0 in BEQ; ALU_CONTROL=001; 3 cycles each.
- jal -> IMM_SRC=11 in DECODE; PC_WRITE=1 in JAL; then ALU_WB with REG_WRITE=1.
- OP=0000000 -> TRAP, ILLEGAL=1 sticky, no enables for 20 cycles. Then assert RST asynchronously mid-cycle -> STATE=0 and ILLEGAL=0 immediately.
